pc_sequencer: RTL

Next-PC controller for the single-cycle MIPS core. Each cycle it selects the PC register's load value and enable from the sequential, branch, jump, jr, exception and eret sources. It holds EPC, Cause and an exception-level flag, and runs a small run/halt/single-step FSM for debug. It sits between the decoder/ALU and the PC register, and drives that register's data input and enable.

---
 rtl/pc_sequencer_pkg.sv | 27 ++
 rtl/pc_sequencer_npc_mux.sv | 69 ++++++
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared constants for the next-PC sequencer: debug FSM
//               state encoding, exception cause codes and vector defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    // Debug run-control FSM encoding
    localparam logic [1:0] c_st_boot = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_halt = 2'd2;
    localparam logic [1:0] c_st_step = 2'd3;

    // Exception cause codes
    localparam logic [4:0] c_cause_adel = 5'h04;
    localparam logic [4:0] c_cause_sys  = 5'h08;
    localparam logic [4:0] c_cause_bp   = 5'h09;
    localparam logic [4:0] c_cause_tr   = 5'h0d;

    // Boot and exception-handler entry addresses
    localparam logic [31:0] c_reset_vec = 32'h0040_0000;
    localparam logic [31:0] c_exc_vec   = 32'h0040_0004;

endpackage : pc_sequencer_pkg
`default_nettype wire

// File: rtl/pc_sequencer_npc_mux.sv
`default_nettype none
// ============================================================================
// Module      : npc_mux
// Description : Purely combinational next-PC target computation and
//               priority select (exception > eret > jr > j > branch > +4).
// Revision    : 1.0 - initial release
// ============================================================================
module npc_mux
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = c_exc_vec
) (
    input  logic [31:0] i_pc_cur,
    input  logic        i_is_branch,
    input  logic        i_branch_taken,
    input  logic [15:0] i_branch_off,
    input  logic        i_is_j,
    input  logic [25:0] i_j_target,
    input  logic        i_is_jr,
    input  logic [31:0] i_rs_val,
    input  logic        i_exc_req,
    input  logic        i_is_eret,
    input  logic [31:0] i_epc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_pc_sel,
    output logic        o_exc_take,
    output logic        o_misaligned_jr,
    output logic        o_eret_win
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic        w_misaligned_jr;
    logic        w_exc_take;

    // Candidate targets; all arithmetic wraps modulo 2^32
    always_comb begin
        w_pc_plus4      = i_pc_cur + 32'd4;
        w_br_target     = w_pc_plus4 + {{14{i_branch_off[15]}}, i_branch_off, 2'b00};
        w_j_target      = {w_pc_plus4[31:28], i_j_target, 2'b00};
        w_misaligned_jr = i_is_jr && (i_rs_val[1:0] != 2'b00);
        w_exc_take      = i_exc_req || w_misaligned_jr;
    end

    // Priority select; only the winning source is flagged for side effects
    always_comb begin
        o_pc_sel   = w_pc_plus4;
        o_eret_win = 1'b0;
        if (w_exc_take) begin
            o_pc_sel = EXC_VEC;
        end else if (i_is_eret) begin
            o_pc_sel   = i_epc;
            o_eret_win = 1'b1;
        end else if (i_is_jr) begin
            o_pc_sel = i_rs_val;
        end else if (i_is_j) begin
            o_pc_sel = w_j_target;
        end else if (i_is_branch && i_branch_taken) begin
            o_pc_sel = w_br_target;
        end
    end

    assign o_pc_plus4      = w_pc_plus4;
    assign o_exc_take      = w_exc_take;
    assign o_misaligned_jr = w_misaligned_jr;

endmodule : npc_mux
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Next-PC controller. Drives the PC register load value and
//               enable, holds EPC/Cause/EXL and runs the run/halt/step
//               debug FSM. All state updates on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = c_exc_vec
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] pc_cur,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic [15:0] branch_off,
    input  logic        is_j,
    input  logic [25:0] j_target,
    input  logic        is_jr,
    input  logic [31:0] rs_val,
    input  logic        exc_req,
    input  logic [4:0]  exc_cause,
    input  logic        is_eret,
    input  logic        halt_req,
    input  logic        step_req,
    output logic [31:0] pc_next,
    output logic        pc_ena,
    output logic [31:0] epc,
    output logic [4:0]  cause,
    output logic        exl,
    output logic        halted
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_epc;
    logic [4:0]  r_cause;
    logic        r_exl;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_sel;
    logic        w_exc_take;
    logic        w_misaligned_jr;
    logic        w_eret_win;
    logic        w_pc_ena;
    logic        w_halted;

    npc_mux #(
        .EXC_VEC (EXC_VEC)
    ) u_npc_mux (
        .i_pc_cur        (pc_cur),
        .i_is_branch     (is_branch),
        .i_branch_taken  (branch_taken),
        .i_branch_off    (branch_off),
        .i_is_j          (is_j),
        .i_j_target      (j_target),
        .i_is_jr         (is_jr),
        .i_rs_val        (rs_val),
        .i_exc_req       (exc_req),
        .i_is_eret       (is_eret),
        .i_epc           (r_epc),
        .o_pc_plus4      (w_pc_plus4),
        .o_pc_sel        (w_pc_sel),
        .o_exc_take      (w_exc_take),
        .o_misaligned_jr (w_misaligned_jr),
        .o_eret_win      (w_eret_win)
    );

    // FSM state register; a stalled cycle freezes the FSM
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_boot;
        end else if (!stall) begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: step beats resume in HALT; STEP falls back on halt_req
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_boot: w_state_nxt = halt_req ? c_st_halt : c_st_run;
            c_st_run:  w_state_nxt = halt_req ? c_st_halt : c_st_run;
            c_st_halt: begin
                if (step_req) begin
                    w_state_nxt = c_st_step;
                end else if (!halt_req) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_step: w_state_nxt = halt_req ? c_st_halt : c_st_run;
            default:   w_state_nxt = c_st_boot;
        endcase
    end

    // FSM outputs: the PC only advances in RUN/STEP and never while stalled
    always_comb begin
        w_pc_ena = 1'b0;
        w_halted = 1'b0;
        case (r_state)
            c_st_run:  w_pc_ena = !stall;
            c_st_step: w_pc_ena = !stall;
            c_st_halt: w_halted = 1'b1;
            default:   w_pc_ena = 1'b0;
        endcase
    end

    // EPC/Cause/EXL: nested exceptions keep the first EPC and cause
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_epc   <= 32'h0;
            r_cause <= 5'h0;
            r_exl   <= 1'b0;
        end else if (w_pc_ena) begin
            if (w_exc_take) begin
                if (!r_exl) begin
                    r_epc   <= pc_cur;
                    r_cause <= (exc_req || !w_misaligned_jr) ? exc_cause : c_cause_adel;
                    r_exl   <= 1'b1;
                end
            end else if (w_eret_win) begin
                r_exl <= 1'b0;
            end
        end
    end

    // While reset is held the load value is just the sequential address
    assign pc_next = rst ? w_pc_plus4 : w_pc_sel;
    assign pc_ena  = w_pc_ena;
    assign epc     = r_epc;
    assign cause   = r_cause;
    assign exl     = r_exl;
    assign halted  = w_halted;

endmodule : pc_sequencer
`default_nettype wire
